// File: rtl/fft_stage_sequencer_if.sv
// Frame/stage handshake bundle of the FFT stage sequencer.
// master = sequencer side, slave = upstream requester plus stage controllers.
interface fft_stage_sequencer_if #(
    parameter int STAGE_ID_W = 3
);
    logic                  frame_start;
    logic                  stage_finish;
    logic                  stage_start;
    logic [STAGE_ID_W-1:0] stage_sel;
    logic                  busy;
    logic                  frame_done;
    logic [7:0]            frame_count;
    logic                  error;

    modport master (
        input  frame_start,
        input  stage_finish,
        output stage_start,
        output stage_sel,
        output busy,
        output frame_done,
        output frame_count,
        output error
    );

    modport slave (
        output frame_start,
        output stage_finish,
        input  stage_start,
        input  stage_sel,
        input  busy,
        input  frame_done,
        input  frame_count,
        input  error
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Sequences the butterfly stages of one FFT frame via start/finish handshakes.
// Optional per-stage watchdog compiled in with `define FFT_SEQ_TIMEOUT_EN.
module fft_stage_sequencer #(
    parameter int NUM_STAGES     = 5,
    parameter int STAGE_ID_W     = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         reset_n,
    fft_stage_sequencer_if.master        bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [STAGE_ID_W-1:0] LAST_SEL = STAGE_ID_W'(NUM_STAGES - 1);

    if (((1 << STAGE_ID_W) < NUM_STAGES) || (NUM_STAGES < 1) || (TIMEOUT_CYCLES < 1)) begin : g_bad_cfg
        $error("fft_stage_sequencer: invalid NUM_STAGES/STAGE_ID_W/TIMEOUT_CYCLES");
    end

    state_t                state_q, state_d;
    logic [STAGE_ID_W-1:0] sel_q, sel_d;
    logic                  start_q, start_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [7:0]            count_q, count_d;
    logic                  err_q, err_d;

`ifdef FFT_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        count_d = count_q;
        err_d   = err_q;
`ifdef FFT_SEQ_TIMEOUT_EN
        // Counts WAIT cycles without a finish; any other state restarts it.
        tmo_d   = (state_q == S_WAIT && !bus.stage_finish) ? tmo_q + TMO_W'(1) : '0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.frame_start) begin
                    state_d = S_LAUNCH;
                    sel_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.stage_finish) begin
                    if (sel_q == LAST_SEL) begin
                        state_d = S_DONE;
                    end else begin
                        sel_d   = sel_q + STAGE_ID_W'(1);
                        state_d = S_LAUNCH;
                    end
                end
`ifdef FFT_SEQ_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d = S_IDLE;
                    sel_d   = '0;
                    err_d   = 1'b1;
                end
`endif
            end
            S_DONE: begin
                count_d = count_q + 8'd1;
                sel_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        start_d = (state_d == S_LAUNCH);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

`ifdef FFT_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
    assign bus.error = err_q;
`else
    assign bus.error = 1'b0;
`endif

    assign bus.stage_start = start_q;
    assign bus.stage_sel   = sel_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = done_q;
    assign bus.frame_count = count_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer: per-frame timeline reference model.
// Define FFT_SEQ_TIMEOUT_EN for both files to exercise the watchdog scenario.
module tb_fft_stage_sequencer;
    localparam int NUM = 5;
    localparam int IDW = 3;
    localparam int TO  = 64;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    fft_stage_sequencer_if #(.STAGE_ID_W(IDW)) bus ();

    fft_stage_sequencer #(
        .NUM_STAGES(NUM),
        .STAGE_ID_W(IDW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors    = 0;
    int checks    = 0;
    int exp_count = 0;
    bit exp_err   = 1'b0;

    // Reference model: from the frame's stage delays derive when every stage_start,
    // frame_done and the busy window must occur, then drive/observe cycle by cycle.
    // Relative cycle 0 is the cycle frame_start is presented. fixed_d=0 -> random
    // delays; stall<NUM withholds that stage's finish; abort_c>=0 resets mid-frame.
    task automatic run_frame(input bit hold, input bit spur, input int fixed_d,
                             input int stall, input int abort_c);
        int d[NUM];
        int s[NUM];
        int active, done_c, idle_from, end_c;
        bit e_start, e_busy, e_done, e_err, fin;
        logic [IDW-1:0] e_sel;
        active = (stall < NUM) ? stall + 1 : NUM;
        for (int i = 0; i < NUM; i++) begin
            d[i] = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, 6));
            if (i == stall) d[i] = TO;
            s[i] = (i == 0) ? 1 : s[i-1] + d[i-1] + 1;
        end
        if (stall < NUM) begin
            done_c    = -1;
            idle_from = s[stall] + TO + 1;
            end_c     = idle_from;
        end else begin
            done_c    = s[NUM-1] + d[NUM-1] + 1;
            idle_from = done_c + 1;
            end_c     = done_c;
        end
        for (int c = 0; c <= end_c; c++) begin
            @(negedge clk);
            e_start = 1'b0;
            e_sel   = '0;
            for (int i = 0; i < active; i++) begin
                if (c == s[i]) e_start = 1'b1;
                if (c >= s[i] && c <= s[i] + d[i]) e_sel = IDW'(i);
            end
            if (c == done_c) e_sel = IDW'(NUM - 1);
            e_busy = (c >= 1) && (c < idle_from);
            e_done = (c == done_c);
`ifdef FFT_SEQ_TIMEOUT_EN
            e_err  = (c == 0) ? exp_err : ((stall < NUM) && (c >= idle_from));
`else
            e_err  = 1'b0;
`endif
            checks += 6;
            if (bus.stage_start !== e_start) begin
                errors++; $display("FAIL stage_start c=%0d got=%b exp=%b", c, bus.stage_start, e_start);
            end
            if (bus.stage_sel !== e_sel) begin
                errors++; $display("FAIL stage_sel c=%0d got=%0d exp=%0d", c, bus.stage_sel, e_sel);
            end
            if (bus.busy !== e_busy) begin
                errors++; $display("FAIL busy c=%0d got=%b exp=%b", c, bus.busy, e_busy);
            end
            if (bus.frame_done !== e_done) begin
                errors++; $display("FAIL frame_done c=%0d got=%b exp=%b", c, bus.frame_done, e_done);
            end
            if (bus.frame_count !== 8'(exp_count)) begin
                errors++; $display("FAIL frame_count c=%0d got=%0d exp=%0d", c, bus.frame_count, exp_count);
            end
            if (bus.error !== e_err) begin
                errors++; $display("FAIL error c=%0d got=%b exp=%b", c, bus.error, e_err);
            end
            if (c == abort_c) begin
                reset_n = 1'b0;
                #1;
                checks++;
                if ({bus.stage_start, bus.stage_sel, bus.busy, bus.frame_done, bus.frame_count, bus.error} !== '0) begin
                    errors++;
                    $display("FAIL async_reset got start=%b sel=%0d busy=%b done=%b cnt=%0d err=%b exp all 0",
                             bus.stage_start, bus.stage_sel, bus.busy, bus.frame_done, bus.frame_count, bus.error);
                end
                bus.frame_start  = 1'b0;
                bus.stage_finish = 1'b0;
                exp_count = 0;
                exp_err   = 1'b0;
                return;
            end
            fin = 1'b0;
            for (int i = 0; i < active; i++) begin
                if (i != stall && c == s[i] + d[i]) fin = 1'b1;
                if (spur && c == s[i]) fin = 1'b1;
            end
            if (spur && (c == 0 || c == done_c)) fin = 1'b1;
            bus.frame_start  = (c == 0) || hold;
            bus.stage_finish = fin;
        end
        if (done_c >= 0) exp_count = (exp_count + 1) % 256;
`ifdef FFT_SEQ_TIMEOUT_EN
        exp_err = (stall < NUM);
`endif
    endtask

    task automatic test_reset();
        bus.frame_start  = 1'b0;
        bus.stage_finish = 1'b0;
        reset_n          = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.stage_start, bus.stage_sel, bus.busy, bus.frame_done, bus.frame_count, bus.error} !== '0) begin
                errors++;
                $display("FAIL reset_idle c=%0d got start=%b sel=%0d busy=%b done=%b cnt=%0d err=%b exp all 0",
                         c, bus.stage_start, bus.stage_sel, bus.busy, bus.frame_done, bus.frame_count, bus.error);
            end
        end
    endtask

    task automatic test_nominal();
        run_frame(1'b0, 1'b0, 4, NUM, -1);
        @(negedge clk);
        checks++;
        if (bus.frame_count !== 8'd1) begin
            errors++; $display("FAIL nominal_count got=%0d exp=1", bus.frame_count);
        end
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 6; n++) run_frame(1'b0, 1'($urandom_range(0, 1)), 0, NUM, -1);
    endtask

    task automatic test_back_to_back();
        run_frame(1'b1, 1'b0, 0, NUM, -1);
        run_frame(1'b1, 1'b0, 0, NUM, -1);
        run_frame(1'b0, 1'b0, 0, NUM, -1);
    endtask

    task automatic test_spurious_finish();
        run_frame(1'b0, 1'b1, 2, NUM, -1);
        run_frame(1'b0, 1'b1, 0, NUM, -1);
    endtask

`ifdef FFT_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        run_frame(1'b0, 1'b0, 0, 2, -1);
        @(negedge clk);
        checks++;
        if (bus.error !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL timeout_sticky got err=%b busy=%b exp err=1 busy=0", bus.error, bus.busy);
        end
        run_frame(1'b0, 1'b0, 0, NUM, -1);
    endtask
`endif

    task automatic test_abort_and_wrap();
        // Fixed delay 3: stage 3 starts at relative cycle 13, so 14 is inside its WAIT.
        run_frame(1'b0, 1'b0, 3, NUM, 14);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.frame_count !== 8'd0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
            errors++; $display("FAIL post_abort got cnt=%0d busy=%b done=%b exp 0 0 0",
                               bus.frame_count, bus.busy, bus.frame_done);
        end
        for (int n = 0; n < 256; n++) run_frame(1'b0, 1'b0, 1, NUM, -1);
        @(negedge clk);
        checks++;
        if (bus.frame_count !== 8'd0) begin
            errors++; $display("FAIL count_wrap got=%0d exp=0", bus.frame_count);
        end
    endtask

    initial begin
        bus.frame_start  = 1'b0;
        bus.stage_finish = 1'b0;
        test_reset();
        test_nominal();
        test_random_frames();
        test_back_to_back();
        test_spurious_finish();
`ifdef FFT_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_abort_and_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
